// File: rtl/ex_result_stage.sv
// ex_result_stage
//   Execute-stage output register downstream of the ALU/shifter. It is a
//   valid/ready stage with a 2-entry skid buffer (head + skid), so an upstream
//   stall never drops a result. It also owns the architectural Z/V/N flags,
//   which are updated in program order as results are accepted.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   flush                    discard all buffered results (branch mispredict)
//   in_valid/in_ready        upstream handshake
//   in_result/in_dst/in_wr_en/in_op/in_ovfl  incoming result and attributes
//   out_valid/out_ready      downstream handshake
//   out_result/out_dst/out_wr_en  head entry
//   flag_z/flag_v/flag_n     architectural flags
//   stall_cnt                (only with EX_RESULT_STALL_CNT_EN) saturating
//                            count of cycles with out_valid & !out_ready
//
// Optional feature macro: EX_RESULT_STALL_CNT_EN
module ex_result_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [REG_W-1:0]  in_dst,
  input  logic              in_wr_en,
  input  logic [3:0]        in_op,
  input  logic              in_ovfl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_dst,
  output logic              out_wr_en,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
`ifdef EX_RESULT_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  dst;
    logic              wr_en;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   z_q, z_d, v_q, v_d, n_q, n_d;
  logic   in_fire, out_fire;

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign in_entry  = '{result: in_result, dst: in_dst, wr_en: in_wr_en};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    z_d     = z_q;
    v_d     = v_q;
    n_d     = n_q;

    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          head_d  = in_entry;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = S_TWO;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          head_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flags follow the accepted instruction; a flushed one never touches them.
    if (in_fire && !flush) begin
      if (in_op[3:1] == 3'b000) begin
        z_d = (in_result == '0);
        n_d = in_result[DATA_W-1];
        v_d = in_ovfl;
      end else if (!in_op[3]) begin
        z_d = (in_result == '0);
      end
    end

    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      z_q     <= z_d;
      v_q     <= v_d;
      n_q     <= n_d;
    end
  end

  assign out_result = head_q.result;
  assign out_dst    = head_q.dst;
  assign out_wr_en  = head_q.wr_en;
  assign flag_z     = z_q;
  assign flag_v     = v_q;
  assign flag_n     = n_q;

`ifdef EX_RESULT_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_dst;
  logic        in_wr_en;
  logic [3:0]  in_op;
  logic        in_ovfl;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        out_wr_en;
  logic        flag_z, flag_v, flag_n;
`ifdef EX_RESULT_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_result_stage #(.DATA_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dst(in_dst), .in_wr_en(in_wr_en),
    .in_op(in_op), .in_ovfl(in_ovfl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst), .out_wr_en(out_wr_en),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
`ifdef EX_RESULT_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Reference model: a FIFO of at most two entries plus plain flag variables.
  typedef struct {
    logic [15:0] r;
    logic [3:0]  d;
    logic        w;
  } ent_t;

  ent_t        mq[$];
  logic        mz = 1'b0, mv = 1'b0, mn = 1'b0;
  int unsigned mcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("m_out_result", {16'd0, out_result}, {16'd0, mq[0].r});
      chk("m_out_dst", {28'd0, out_dst}, {28'd0, mq[0].d});
      chk("m_out_wr_en", {31'd0, out_wr_en}, {31'd0, mq[0].w});
    end
    chk("m_flags", {29'd0, flag_z, flag_v, flag_n}, {29'd0, mz, mv, mn});
`ifdef EX_RESULT_STALL_CNT_EN
    chk("m_stall_cnt", {16'd0, stall_cnt}, mcnt);
`endif
  endtask

  // One clock: inputs already driven; model advances from the pre-edge view.
  task automatic tick();
    bit   ifire, ofire, stall;
    ent_t e;
    ifire = in_valid && (mq.size() < 2);
    ofire = (mq.size() > 0) && out_ready;
    stall = (mq.size() > 0) && !out_ready;
    e = '{r: in_result, d: in_dst, w: in_wr_en};
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      mz = 1'b0; mv = 1'b0; mn = 1'b0;
      mcnt = 0;
    end else begin
      if (stall && mcnt < 65535) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) begin
          mq.push_back(e);
          if (in_op <= 4'd1) begin
            mz = (e.r == 16'd0);
            mn = (e.r >= 16'h8000);
            mv = in_ovfl;
          end else if (in_op <= 4'd7) begin
            mz = (e.r == 16'd0);
          end
        end
      end
    end
    check_model();
  endtask

  typedef struct {
    bit          iv, ordy, fl;
    logic [15:0] res;
    logic [3:0]  op;
    bit          ov;
    bit          e_ir, e_ovld;
    logic [15:0] e_res;
    bit          ez, ev, en;
  } vec_t;

  vec_t vt[14];

  initial begin
    //            iv ordy fl res       op   ov  | ir ovld res       z  v  n
    vt[0]  = '{1, 1, 0, 16'h0000, 4'h1, 0, 1, 1, 16'h0000, 1, 0, 0};
    vt[1]  = '{0, 1, 0, 16'h0000, 4'h8, 0, 1, 0, 16'h0000, 1, 0, 0};
    vt[2]  = '{1, 0, 0, 16'h1111, 4'h8, 0, 1, 1, 16'h1111, 1, 0, 0};
    vt[3]  = '{1, 0, 0, 16'h2222, 4'h8, 0, 0, 1, 16'h1111, 1, 0, 0};
    vt[4]  = '{1, 0, 0, 16'h3333, 4'h8, 0, 0, 1, 16'h1111, 1, 0, 0};
    vt[5]  = '{1, 1, 0, 16'h3333, 4'h8, 0, 1, 1, 16'h2222, 1, 0, 0};
    vt[6]  = '{1, 1, 0, 16'h3333, 4'h8, 0, 1, 1, 16'h3333, 1, 0, 0};
    vt[7]  = '{1, 1, 0, 16'h8000, 4'h0, 1, 1, 1, 16'h8000, 0, 1, 1};
    vt[8]  = '{1, 1, 0, 16'h0000, 4'h5, 0, 1, 1, 16'h0000, 1, 1, 1};
    vt[9]  = '{1, 0, 0, 16'h0005, 4'h2, 0, 0, 1, 16'h0000, 0, 1, 1};
    vt[10] = '{1, 0, 1, 16'h0000, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 1};
    vt[11] = '{1, 1, 0, 16'hFFFF, 4'h9, 0, 1, 1, 16'hFFFF, 0, 1, 1};
    vt[12] = '{1, 1, 0, 16'h7FFF, 4'h1, 0, 1, 1, 16'h7FFF, 0, 0, 0};
    vt[13] = '{0, 1, 0, 16'h0000, 4'h0, 0, 1, 0, 16'h0000, 0, 0, 0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_dst = '0; in_wr_en = 1'b0; in_op = '0; in_ovfl = 1'b0;
    tick();
    tick();
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_out_dst", {28'd0, out_dst}, 32'd0);
    chk("rst_out_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_v, flag_n}, 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      in_valid  = vt[i].iv;
      out_ready = vt[i].ordy;
      flush     = vt[i].fl;
      in_result = vt[i].res;
      in_op     = vt[i].op;
      in_ovfl   = vt[i].ov;
      in_dst    = 4'(i);
      in_wr_en  = i[0];
      tick();
      chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].e_ir});
      chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_ovld});
      if (vt[i].e_ovld)
        chk($sformatf("tbl%0d_out_result", i), {16'd0, out_result}, {16'd0, vt[i].e_res});
      chk($sformatf("tbl%0d_flags", i), {29'd0, flag_z, flag_v, flag_n},
          {29'd0, vt[i].ez, vt[i].ev, vt[i].en});
    end
    flush = 1'b0;

    // Continuous stream: one result per cycle, 1-cycle latency.
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_result = 16'hA000 + 16'(i);
      in_op     = 4'hC;
      tick();
      chk($sformatf("stream%0d_result", i), {16'd0, out_result}, {16'd0, 16'hA000 + 16'(i)});
      chk($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("stream%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
    end

`ifdef EX_RESULT_STALL_CNT_EN
    // Five stalled cycles with one entry held at the head.
    rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("stall_cnt_after_flush", {16'd0, stall_cnt}, 32'd6);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 4'($urandom);
      in_result = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      in_ovfl   = 1'($urandom);
      in_dst    = 4'($urandom);
      in_wr_en  = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Execute-stage output register that sits directly downstream of the ALU/shifter datapath; consumes its 16-bit result and forwards it toward MEM/WB.
- Valid/ready pipeline stage with a 2-entry skid buffer so an upstream stall never drops a shifted or ALU result.
- Owns the architectural flag register (Z, V, N) and updates it in program order as results are accepted.

Parameters:
DATA_W, 16, result width
REG_W, 4, destination register index width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered results (branch mispredict)
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept a result this cycle
in_result  input  DATA_W  ALU/shifter result
in_dst  input  REG_W  destination register index
in_wr_en  input  1  result is to be written back
in_op  input  4  opcode of producing instruction
in_ovfl  input  1  ALU signed overflow for ADD/SUB
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head entry
out_result  output  DATA_W  head result
out_dst  output  REG_W  head destination
out_wr_en  output  1  head write-enable
flag_z  output  1  zero flag
flag_v  output  1  overflow flag
flag_n  output  1  negative flag

Behaviour:
- Reset (rst high at clk edge): state EMPTY; in_ready=1, out_valid=0, out_result=0, out_dst=0, out_wr_en=0, flags=0. Reset overrides flush and all handshakes.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: head register (drives out_*), skid register. All outputs are registered; no combinational in->out path; in_ready is a registered function of state.
- States:
  - EMPTY: in_fire -> ONE (load head).
  - ONE: in_fire & out_fire -> ONE (head replaced). in_fire only -> TWO (load skid). out_fire only -> EMPTY.
  - TWO: in_ready=0. out_fire -> ONE (skid moves to head).
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- Latency: an accepted result appears on out_* the next cycle. Throughput is 1 per cycle when out_ready stays high.
- Strict FIFO order; no entry is duplicated or lost except by flush.
- Flag update occurs on in_fire only, visible the cycle after:
  - in_op 0000 (ADD) and 0001 (SUB): Z = (in_result==0), N = in_result[DATA_W-1], V = in_ovfl.
  - in_op 0010–0111 (XOR, RED, SLL, SRA, ROR, PADDSB): Z updated only; V and N hold.
  - in_op 1000–1111: no flag change.
- Flush: next state EMPTY. in_ready=1 and out_valid=0 the following cycle. A simultaneous in_fire is dropped and does not update flags. Flags are never rolled back.
- out_ready may be asserted while out_valid=0; this has no effect.
- Shift results with in_result==0 (e.g. SLL by 15 of 0x0001 followed by a further shift) set Z like any other op in the Z-only class.

Optional Feature:
- Macro EX_RESULT_STALL_CNT_EN.
- Defined: adds output port stall_cnt (16 bits), reset 0. It increments each cycle that out_valid & !out_ready, saturates at 0xFFFF, and is cleared by rst only (flush does not clear it).
- Not defined: port absent, no counter logic.

Test Plan:
- Reset, then in_op=0001, in_result=0x0000, in_ovfl=0, out_ready=1 -> next cycle out_result=0x0000, out_valid=1; flags Z=1, N=0, V=0.
- out_ready=0; push 0x1111 then 0x2222 -> in_ready=0 after the second accept, 0x3333 held off upstream; raise out_ready -> outputs 0x1111, 0x2222, 0x3333 in order with no gaps.
- ADD with result 0x8000, in_ovfl=1 -> Z=0, N=1, V=1. Then SRA (0101) with result 0x0000 -> Z=1 while N=1 and V=1 hold.
- In TWO state, assert flush together with in_valid (in_op=0000, result 0) -> next cycle out_valid=0, in_ready=1, flags unchanged.
- Stream 8 results with out_ready=1 and in_valid=1 continuously -> one output per cycle, 1-cycle latency, in_ready never drops.
- With EX_RESULT_STALL_CNT_EN defined: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5. Preload near 0xFFFE, stall 3 cycles -> stall_cnt stays at 0xFFFF.
